// File: rtl/excp_ctrl.sv
// excp_ctrl -- multicycle exception sequencer.
//
// Accepts exception requests from the main control unit while idle. It then
// steps through EPC save, vector read, an optional memory wait, and PC load,
// and ends with a one-cycle done pulse. The main FSM is stalled
// (excp_busy) from SAVE through LOAD. All outputs are decoded from registered
// state and cause (Moore), so no input reaches an output combinationally.
//
// Optional feature: define EXCP_DIV0_EN to make excp_div0 a lowest-priority
// exception source (code 11). Without it the excp_div0 port is ignored.
//
// Parameters:
//   MEM_LAT       memory wait cycles after the vector read request (0..15)
// Ports:
//   clk           rising-edge clock
//   reset         asynchronous, active-high reset
//   excp_opcode   invalid-opcode request   (code 01, highest priority)
//   excp_ovf      overflow request         (code 10)
//   excp_div0     divide-by-zero request   (code 11, lowest, EXCP_DIV0_EN only)
//   flagExcpCtrl  vector mux select; cause while busy, 00 otherwise
//   epc_write     EPC write enable (SAVE)
//   mem_read      vector byte read (READ)
//   pc_load       PC load from vector byte (LOAD)
//   excp_busy     stall to the main control unit
//   excp_done     one-cycle completion pulse (DONE)
//   cause         sticky code of the last accepted exception
module excp_ctrl #(
    parameter int unsigned MEM_LAT = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       excp_opcode,
    input  logic       excp_ovf,
    input  logic       excp_div0,
    output logic [1:0] flagExcpCtrl,
    output logic       epc_write,
    output logic       mem_read,
    output logic       pc_load,
    output logic       excp_busy,
    output logic       excp_done,
    output logic [1:0] cause
);

    typedef enum logic [2:0] {
        IDLE,
        SAVE,
        READ,
        WAIT,
        LOAD,
        DONE
    } state_t;

    localparam logic [3:0] LAT = MEM_LAT[3:0];

    state_t     state;
    state_t     nextState;
    logic [3:0] waitCnt;
    logic [1:0] reqCode;

    // Later assignments override earlier ones, so the last test wins:
    // opcode > ovf > div0.
`ifdef EXCP_DIV0_EN
    always_comb begin
        reqCode = 2'b00;
        if (excp_div0)   reqCode = 2'b11;
        if (excp_ovf)    reqCode = 2'b10;
        if (excp_opcode) reqCode = 2'b01;
    end
`else
    logic unusedDiv0;
    assign unusedDiv0 = excp_div0;

    always_comb begin
        reqCode = 2'b00;
        if (excp_ovf)    reqCode = 2'b10;
        if (excp_opcode) reqCode = 2'b01;
    end
`endif

    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (reqCode != 2'b00) nextState = SAVE;
            SAVE:    nextState = READ;
            READ:    nextState = (LAT == 4'd0) ? LOAD : WAIT;
            // The counter was loaded with LAT in READ, so leaving at 1
            // gives exactly LAT cycles in WAIT.
            WAIT:    if (waitCnt == 4'd1) nextState = LOAD;
            LOAD:    nextState = DONE;
            DONE:    nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            waitCnt <= '0;
            cause   <= '0;
        end else begin
            state <= nextState;
            if (state == IDLE && reqCode != 2'b00) begin
                cause <= reqCode;
            end
            if (state == READ) begin
                waitCnt <= LAT;
            end else if (state == WAIT) begin
                waitCnt <= waitCnt - 4'd1;
            end
        end
    end

    assign epc_write    = (state == SAVE);
    assign mem_read     = (state == READ);
    assign pc_load      = (state == LOAD);
    assign excp_done    = (state == DONE);
    assign excp_busy    = (state == SAVE) || (state == READ) ||
                          (state == WAIT) || (state == LOAD);
    assign flagExcpCtrl = excp_busy ? cause : 2'b00;

endmodule

// File: tb/tb_excp_ctrl.sv
// Bench for excp_ctrl: two instances (MEM_LAT=2 and MEM_LAT=0) share the
// stimulus. A phase-count model predicts every output each cycle, and
// directed scenarios pin the model with hand-computed expectations.
module tb_excp_ctrl;

    localparam int LAT0 = 2;
    localparam int LAT1 = 0;
`ifdef EXCP_DIV0_EN
    localparam bit DIV0 = 1'b1;
`else
    localparam bit DIV0 = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic excp_opcode = 1'b0;
    logic excp_ovf = 1'b0;
    logic excp_div0 = 1'b0;

    logic [1:0] flag0, flag1, cause0, cause1;
    logic epc0, epc1, mem0, mem1, pcl0, pcl1, busy0, busy1, done0, done1;

    int passCnt = 0;
    int totalCnt = 0;
    bit started = 1'b0;

    always #5 clk = ~clk;

    excp_ctrl #(.MEM_LAT(LAT0)) dut (
        .clk(clk), .reset(reset),
        .excp_opcode(excp_opcode), .excp_ovf(excp_ovf), .excp_div0(excp_div0),
        .flagExcpCtrl(flag0), .epc_write(epc0), .mem_read(mem0),
        .pc_load(pcl0), .excp_busy(busy0), .excp_done(done0), .cause(cause0)
    );

    excp_ctrl #(.MEM_LAT(LAT1)) dut0 (
        .clk(clk), .reset(reset),
        .excp_opcode(excp_opcode), .excp_ovf(excp_ovf), .excp_div0(excp_div0),
        .flagExcpCtrl(flag1), .epc_write(epc1), .mem_read(mem1),
        .pc_load(pcl1), .excp_busy(busy1), .excp_done(done1), .cause(cause1)
    );

    // Packed view: {flag[1:0], epc, mem, pcl, busy, done, cause[1:0]}
    logic [8:0] act0, act1;
    assign act0 = {flag0, epc0, mem0, pcl0, busy0, done0, cause0};
    assign act1 = {flag1, epc1, mem1, pcl1, busy1, done1, cause1};

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        totalCnt++;
        if (act === exp) passCnt++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Model: phase = cycles since acceptance (0 = idle). Sequence length is
    // 4+L cycles: 1 save, 2 read, 3..2+L wait, 3+L load, 4+L done.
    int ph[2] = '{0, 0};
    logic [1:0] mc[2] = '{2'b00, 2'b00};

    function automatic int latOf(input int k);
        return (k == 0) ? LAT0 : LAT1;
    endfunction

    function automatic logic [1:0] winner(input logic o, input logic v, input logic d);
        if (o) return 2'b01;
        if (v) return 2'b10;
        if (d && DIV0) return 2'b11;
        return 2'b00;
    endfunction

    function automatic logic [8:0] expv(input int k);
        int p = ph[k];
        int l = latOf(k);
        logic busy = (p >= 1) && (p <= 3 + l);
        logic [1:0] f = busy ? mc[k] : 2'b00;
        return {f, logic'(p == 1), logic'(p == 2), logic'(p == 3 + l), busy,
                logic'(p == 4 + l), mc[k]};
    endfunction

    always @(posedge clk or posedge reset) begin
        for (int k = 0; k < 2; k++) begin
            if (reset) begin
                ph[k] = 0;
                mc[k] = 2'b00;
            end else if (ph[k] == 0) begin
                logic [1:0] w;
                w = winner(excp_opcode, excp_ovf, excp_div0);
                if (w != 2'b00) begin
                    mc[k] = w;
                    ph[k] = 1;
                end
            end else if (ph[k] == 4 + latOf(k)) begin
                ph[k] = 0;
            end else begin
                ph[k] = ph[k] + 1;
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            chk("model_lat2", {7'd0, act0}, {7'd0, expv(0)});
            chk("model_lat0", {7'd0, act1}, {7'd0, expv(1)});
        end
    end

    task automatic step(input logic o, input logic v, input logic d, input logic r);
        @(posedge clk);
        #2;
        excp_opcode = o;
        excp_ovf = v;
        excp_div0 = d;
        reset = r;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0);
    endtask

    initial begin
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        started = 1'b1;
        #1;
        chk("reset_lat2", {7'd0, act0}, 16'h0);
        chk("reset_lat0", {7'd0, act1}, 16'h0);
        step(0, 0, 0, 0);

        // Overflow pulse, MEM_LAT=2.
        step(0, 1, 0, 0);
        step(0, 0, 0, 0);
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk);
            chk("ovf_flag", {14'd0, flag0}, (c >= 1 && c <= 5) ? 16'h2 : 16'h0);
            chk("ovf_epc",  {15'd0, epc0},  {15'd0, c == 1});
            chk("ovf_mem",  {15'd0, mem0},  {15'd0, c == 2});
            chk("ovf_pcl",  {15'd0, pcl0},  {15'd0, c == 5});
            chk("ovf_done", {15'd0, done0}, {15'd0, c == 6});
        end
        chk("ovf_cause", {14'd0, cause0}, 16'h2);
        idle(2);

        // Simultaneous requests: opcode wins.
        step(1, 1, 1, 0);
        step(0, 0, 0, 0);
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            chk("prio_flag", {14'd0, flag0}, 16'h1);
        end
        chk("prio_cause", {14'd0, cause0}, 16'h1);
        idle(3);

        // MEM_LAT=0 timing on dut0.
        step(1, 0, 0, 0);
        step(0, 0, 0, 0);
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            chk("lat0_pcl",  {15'd0, pcl1},  {15'd0, c == 3});
            chk("lat0_done", {15'd0, done1}, {15'd0, c == 4});
        end
        idle(3);

        // Overflow raised during WAIT is ignored.
        step(1, 0, 0, 0);
        step(0, 0, 0, 0);   // cycle 1
        step(0, 0, 0, 0);   // cycle 2
        step(0, 1, 0, 0);   // cycle 3 (WAIT), sampled at its ending edge
        chk("wait_busy", {15'd0, busy0}, 16'h1);
        step(0, 0, 0, 0);
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            chk("ign_epc", {15'd0, epc0}, 16'h0);
        end
        chk("ign_cause", {14'd0, cause0}, 16'h1);
        idle(1);

        // Reset asserted in WAIT.
        step(0, 1, 0, 0);
        step(0, 0, 0, 0);   // cycle 1
        step(0, 0, 0, 0);   // cycle 2
        @(posedge clk);     // enter cycle 3 (WAIT)
        #2;
        chk("prerst_flag", {14'd0, flag0}, 16'h2);
        reset = 1'b1;
        #1;
        chk("rst_mid_lat2", {7'd0, act0}, 16'h0);
        step(0, 0, 0, 0);
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            chk("rst_no_pcl", {15'd0, pcl0}, 16'h0);
        end

        // Lone div0.
        step(0, 0, 1, 0);
        step(0, 0, 0, 0);
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (DIV0) chk("div0_flag", {14'd0, flag0}, (c <= 5) ? 16'h3 : 16'h0);
            else      chk("div0_busy", {15'd0, busy0}, 16'h0);
        end
        chk("div0_cause", {14'd0, cause0}, DIV0 ? 16'h3 : 16'h0);

        // Held request re-triggers.
        for (int i = 0; i < 20; i++) step(0, 1, 0, 0);
        idle(8);

        // Random traffic.
        for (int i = 0; i < 500; i++) begin
            step($urandom_range(0, 7) == 0, $urandom_range(0, 5) == 0,
                 $urandom_range(0, 4) == 0, $urandom_range(0, 60) == 0);
        end
        idle(10);

        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end

endmodule
